// File: rtl/memory_control.sv
// memory_control: single-port RAM arbiter between instruction fetch and data
// access. Data requests win over fetches; a watchdog aborts accesses the RAM
// never completes and raises a sticky error flag.
module memory_control #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        merr
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [WORD_W-1:0] ABORT_VAL = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DRESP,
        IRESP
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               wflag, wflag_d;
    logic [WORD_W-1:0]  addr_d, store_d, iload_d, dload_d;
    logic               merr_d, ihit_d, dhit_d, ren_d, wen_d;

    // State register and registered outputs; reset is synchronous.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            wflag    <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
            merr     <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wflag    <= wflag_d;
            ramaddr  <= addr_d;
            ramstore <= store_d;
            iload    <= iload_d;
            dload    <= dload_d;
            merr     <= merr_d;
            ihit     <= ihit_d;
            dhit     <= dhit_d;
            ramREN   <= ren_d;
            ramWEN   <= wen_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // line up with the state register without any input-to-output path.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wflag_d = wflag;
        addr_d  = ramaddr;
        store_d = ramstore;
        iload_d = iload;
        dload_d = dload;
        merr_d  = merr;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    store_d = dstore;
                    wflag_d = dWEN;
                    state_d = DACC;
                end else if (iREN) begin
                    addr_d  = iaddr;
                    state_d = IACC;
                end
            end
            DACC: begin
                cnt_d = cnt + CNT_W'(1);
                if (ramready) begin
                    if (!wflag) dload_d = ramload;
                    state_d = DRESP;
                end else if (cnt == CNT_LAST) begin
                    if (!wflag) dload_d = ABORT_VAL;
                    merr_d  = 1'b1;
                    state_d = DRESP;
                end
            end
            IACC: begin
                cnt_d = cnt + CNT_W'(1);
                if (ramready) begin
                    iload_d = ramload;
                    state_d = IRESP;
                end else if (cnt == CNT_LAST) begin
                    iload_d = ABORT_VAL;
                    merr_d  = 1'b1;
                    state_d = IRESP;
                end
            end
            DRESP, IRESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        dhit_d = (state_d == DRESP);
        ihit_d = (state_d == IRESP);
        ren_d  = (state_d == IACC) || ((state_d == DACC) && !wflag_d);
        wen_d  = (state_d == DACC) && wflag_d;
    end

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control with hand-computed expected values.
module tb_memory_control;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b0;
    logic        merr;

    int errors = 0;
    int checks = 0;

    memory_control #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready),
        .merr(merr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held two cycles with both requests pending.
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h4; daddr = 32'h40;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ramREN", 32'(ramREN), 32'd0);
            check("rst_ramWEN", 32'(ramWEN), 32'd0);
            check("rst_ihit",   32'(ihit),   32'd0);
            check("rst_dhit",   32'(dhit),   32'd0);
            check("rst_merr",   32'(merr),   32'd0);
            check("rst_ramaddr", ramaddr, 32'h0);
            check("rst_ramstore", ramstore, 32'h0);
            check("rst_iload",  iload, 32'h0);
            check("rst_dload",  dload, 32'h0);
        end
        RST = 1'b0;
        check("post_rst_ihit", 32'(ihit), 32'd0);
        tick();
        check("post_rst_ramREN", 32'(ramREN), 32'd1);
        check("post_rst_ramaddr", ramaddr, 32'h40);
        check("post_rst_ihit1", 32'(ihit), 32'd0);
        // Withdraw both requests; the data access still completes.
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b1; ramload = 32'h1111_1111;
        tick();
        ramready = 1'b0;
        check("withdrawn_dhit", 32'(dhit), 32'd1);
        check("withdrawn_dload", dload, 32'h1111_1111);
        check("withdrawn_ihit", 32'(ihit), 32'd0);
        tick();
        check("idle_dhit", 32'(dhit), 32'd0);

        // Fetch with minimum latency.
        iREN = 1'b1; iaddr = 32'h4;
        tick();
        check("fetch_ramREN", 32'(ramREN), 32'd1);
        check("fetch_ramaddr", ramaddr, 32'h4);
        check("fetch_ihit_early", 32'(ihit), 32'd0);
        ramready = 1'b1; ramload = 32'h2001_0001;
        tick();
        ramready = 1'b0; iREN = 1'b0;
        check("fetch_ihit", 32'(ihit), 32'd1);
        check("fetch_iload", iload, 32'h2001_0001);
        check("fetch_ramREN_resp", 32'(ramREN), 32'd0);
        tick();
        check("fetch_ihit_once", 32'(ihit), 32'd0);

        // Simultaneous requests: data first, then fetch.
        iREN = 1'b1; iaddr = 32'h8; dREN = 1'b1; daddr = 32'h100;
        tick();
        check("prio_ramaddr_d", ramaddr, 32'h100);
        check("prio_ramREN_d", 32'(ramREN), 32'd1);
        ramready = 1'b1; ramload = 32'hAAAA_5555;
        tick();
        ramready = 1'b0; dREN = 1'b0;
        check("prio_dhit", 32'(dhit), 32'd1);
        check("prio_ihit_none", 32'(ihit), 32'd0);
        check("prio_dload", dload, 32'hAAAA_5555);
        tick();
        check("prio_idle_ramREN", 32'(ramREN), 32'd0);
        tick();
        check("prio_ramaddr_i", ramaddr, 32'h8);
        check("prio_ramREN_i", 32'(ramREN), 32'd1);
        ramready = 1'b1; ramload = 32'h1234_5678;
        tick();
        ramready = 1'b0; iREN = 1'b0;
        check("prio_ihit", 32'(ihit), 32'd1);
        check("prio_dhit_none", 32'(dhit), 32'd0);
        check("prio_iload", iload, 32'h1234_5678);
        tick();

        // Write; requester address/data changes during access are ignored.
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFE_F00D;
        tick();
        daddr = 32'hFFFF_FFF0; dstore = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("wr_ramWEN", 32'(ramWEN), 32'd1);
            check("wr_ramREN", 32'(ramREN), 32'd0);
            check("wr_ramstore", ramstore, 32'hCAFE_F00D);
            check("wr_ramaddr", ramaddr, 32'h80);
            check("wr_dhit_early", 32'(dhit), 32'd0);
            if (i == 2) begin
                ramready = 1'b1; ramload = 32'h5A5A_5A5A;
            end
            tick();
        end
        ramready = 1'b0; dWEN = 1'b0;
        check("wr_dhit", 32'(dhit), 32'd1);
        check("wr_dload_kept", dload, 32'hAAAA_5555);
        check("wr_ramWEN_resp", 32'(ramWEN), 32'd0);
        tick();

        // Watchdog abort on a read.
        dREN = 1'b1; daddr = 32'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_ramREN", 32'(ramREN), 32'd1);
            check("to_dhit_early", 32'(dhit), 32'd0);
            tick();
        end
        dREN = 1'b0;
        check("to_dhit", 32'(dhit), 32'd1);
        check("to_dload", dload, 32'hDEAD_BEEF);
        check("to_merr", 32'(merr), 32'd1);
        check("to_ramREN_off", 32'(ramREN), 32'd0);
        tick();
        check("to_merr_sticky", 32'(merr), 32'd1);
        check("to_dhit_once", 32'(dhit), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("to_merr_cleared", 32'(merr), 32'd0);

        // ramready on the last allowed cycle beats the watchdog.
        dREN = 1'b1; daddr = 32'h204;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("late_ramREN", 32'(ramREN), 32'd1);
            if (i == 3) begin
                ramready = 1'b1; ramload = 32'h0BAD_F00D;
            end
            tick();
        end
        ramready = 1'b0; dREN = 1'b0;
        check("late_dhit", 32'(dhit), 32'd1);
        check("late_dload", dload, 32'h0BAD_F00D);
        check("late_merr", 32'(merr), 32'd0);
        tick();

        // Reset on the second access cycle aborts silently.
        dREN = 1'b1; daddr = 32'h300;
        tick();
        check("mr_ramREN1", 32'(ramREN), 32'd1);
        tick();
        check("mr_ramREN2", 32'(ramREN), 32'd1);
        RST = 1'b1; dREN = 1'b0;
        tick();
        RST = 1'b0;
        check("mr_ramREN_rst", 32'(ramREN), 32'd0);
        check("mr_dhit_rst", 32'(dhit), 32'd0);
        check("mr_merr", 32'(merr), 32'd0);
        tick();
        check("mr_dhit_after", 32'(dhit), 32'd0);
        check("mr_ramREN_after", 32'(ramREN), 32'd0);
        // Back in IDLE: a fresh fetch sees minimum latency.
        iREN = 1'b1; iaddr = 32'hC;
        tick();
        check("mr_idle_ramREN", 32'(ramREN), 32'd1);
        check("mr_idle_ramaddr", ramaddr, 32'hC);
        ramready = 1'b1; ramload = 32'h7777_0000;
        tick();
        ramready = 1'b0; iREN = 1'b0;
        check("mr_idle_ihit", 32'(ihit), 32'd1);
        check("mr_idle_iload", iload, 32'h7777_0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
